// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU command sequencer.
//   Opcode constants understood by the external ALU, the error code
//   returned for rejected commands, and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] MUL = 4'd2;
  localparam logic [3:0] DIV = 4'd3;

  localparam logic [7:0] ALU_ERR_CODE = 8'hAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer -- issues one command at a time to an external ALU,
// waits out its fixed latency and returns the result on a valid/ready
// response channel.
//
// Parameter:
//   LAT        ALU latency in cycles from sampling alu_* to registered
//              alu_out/alu_carry (1..7).
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_sel/cmd_a/cmd_b/cmd_tag  command payload
//   rsp_valid/rsp_ready          response handshake
//   rsp_data/rsp_carry/rsp_tag/rsp_err  response payload (held while stalled)
//   alu_sel/alu_a/alu_b          operands driven to the ALU (held between commands)
//   alu_out/alu_carry            ALU registered result
//   busy                         high whenever not in IDLE
//   op_count                     completed responses, wraps at 256
//
// Build option:
//   ALU_SEQ_ERRCHK_EN  when defined, commands with an unknown opcode or a
//                      divide by zero are answered directly with
//                      rsp_data=ALU_ERR_CODE, rsp_err=1, without using the ALU.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_sel,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_tag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic [3:0] rsp_tag,
  output logic       rsp_err,
  output logic [3:0] alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       busy,
  output logic [7:0] op_count
);

  // Loaded on accept; WAIT ends when it reaches zero, giving LAT+1 cycles.
  localparam logic [2:0] LAT_CNT = 3'(LAT);

  seq_state_t state;
  logic [2:0] wait_cnt;
  logic [3:0] tag_hold;
  logic       illegal;

`ifdef ALU_SEQ_ERRCHK_EN
  assign illegal = (cmd_sel > DIV) || ((cmd_sel == DIV) && (cmd_b == 8'd0));
`else
  assign illegal = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_carry <= 1'b0;
      rsp_tag   <= 4'd0;
      rsp_err   <= 1'b0;
      alu_sel   <= 4'd0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      wait_cnt  <= 3'd0;
      tag_hold  <= 4'd0;
      op_count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is registered: it comes up one cycle after reset
          // and one cycle after a response completes.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            tag_hold  <= cmd_tag;
            if (illegal) begin
              // Rejected command never touches the ALU ports.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= ALU_ERR_CODE;
              rsp_carry <= 1'b0;
              rsp_tag   <= cmd_tag;
              rsp_err   <= 1'b1;
            end else begin
              state    <= WAIT;
              alu_sel  <= cmd_sel;
              alu_a    <= cmd_a;
              alu_b    <= cmd_b;
              wait_cnt <= LAT_CNT;
            end
          end
        end

        WAIT: begin
          if (wait_cnt == 3'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_carry <= alu_carry;
            rsp_tag   <= tag_hold;
            rsp_err   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            op_count  <= op_count + 8'd1;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer -- self-checking bench for alu_op_sequencer.
//   Contains a LAT-cycle ALU model in the enclosing level, a stimulus
//   process that pushes expected responses into a scoreboard queue, and
//   a monitor that pops and compares on every response handshake.
module tb_alu_op_sequencer;

  localparam int LAT = 1;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic [3:0] tag;
    logic       err;
  } rsp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_sel = 4'd0;
  logic [7:0] cmd_a = 8'd0;
  logic [7:0] cmd_b = 8'd0;
  logic [3:0] cmd_tag = 4'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [3:0] rsp_tag;
  logic       rsp_err;
  logic [3:0] alu_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       busy;
  logic [7:0] op_count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned last_accept = 0;
  int unsigned issued = 0;
  logic [7:0]  exp_ops = 8'd0;
  bit          rand_ready = 1'b0;
  rsp_t        sb[$];

  alu_op_sequencer #(.LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ALU model: LAT register stages after sampling its operand ports.
  function automatic logic [8:0] alu_calc(input logic [3:0] s, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    case (s)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, p[7:0]};
      4'd3:    return (b == 8'd0) ? 9'h0FF : {1'b0, a / b};
      default: return 9'h000;
    endcase
  endfunction

  logic [8:0] pipe [LAT];
  always_ff @(posedge clock) begin
    pipe[0] <= alu_calc(alu_sel, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_out   = pipe[LAT-1][7:0];
  assign alu_carry = pipe[LAT-1][8];

  // Reference model: expected response from the operation rules.
  function automatic bit is_err(input logic [3:0] sel, input logic [7:0] b);
`ifdef ALU_SEQ_ERRCHK_EN
    return (int'(sel) > 3) || (int'(sel) == 3 && int'(b) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic rsp_t model(input logic [3:0] sel, input logic [7:0] a,
                                 input logic [7:0] b, input logic [3:0] tag);
    rsp_t r;
    int unsigned ua, ub;
    ua = int'(a);
    ub = int'(b);
    r.tag = tag;
    r.err = 1'b0;
    r.carry = 1'b0;
    case (int'(sel))
      0: begin
        r.data  = 8'((ua + ub) % 256);
        r.carry = (ua + ub) > 255;
      end
      1: r.data = 8'((ua + 256 - ub) % 256);
      2: r.data = 8'((ua * ub) % 256);
      3: r.data = (ub == 0) ? 8'd255 : 8'(ua / ub);
      default: r.data = 8'd0;
    endcase
    if (is_err(sel, b)) begin
      r.data  = 8'hAC;
      r.carry = 1'b0;
      r.err   = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one command; optionally check latency to rsp_valid.
  task automatic send(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag, input bit timed);
    int n;
    int lat;
    logic [3:0] pre_sel;
    logic [7:0] pre_a;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    pre_sel = alu_sel;
    pre_a = alu_a;
    cmd_valid = 1'b1;
    cmd_sel = sel;
    cmd_a = a;
    cmd_b = b;
    cmd_tag = tag;
    @(posedge clock);
    sb.push_back(model(sel, a, b, tag));
    issued++;
    #1;
    last_accept = cyc;
    $display("cmd  sel=%0h a=%0d b=%0d tag=%0d at cycle %0d", sel, a, b, tag, cyc);
    cmd_valid = 1'b0;
    cmd_sel = 4'($urandom);
    cmd_a = 8'($urandom);
    cmd_b = 8'($urandom);
    if (is_err(sel, b)) begin
      chk("alu_sel_unchanged", 32'(alu_sel), 32'(pre_sel));
      chk("alu_a_unchanged", 32'(alu_a), 32'(pre_a));
    end else begin
      chk("alu_sel_fwd", 32'(alu_sel), 32'(sel));
      chk("alu_a_fwd", 32'(alu_a), 32'(a));
      chk("alu_b_fwd", 32'(alu_b), 32'(b));
    end
    if (timed) begin
      lat = is_err(sel, b) ? 0 : LAT + 1;
      for (int i = 0; i <= lat; i++) begin
        if (i > 0) begin
          @(posedge clock); #1;
        end
        chk("rsp_valid_latency", 32'(rsp_valid), 32'(i == lat));
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        chk("busy_flag", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Random backpressure while enabled.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard.
  initial begin
    rsp_t e;
    rsp_t held;
    bit   stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 1'b0;
        continue;
      end
      if (rsp_valid) chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
      if (stalled) begin
        chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
        chk("rsp_payload_held", 32'({rsp_data, rsp_carry, rsp_tag, rsp_err}), 32'(held));
      end
      if (rsp_valid && rsp_ready) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("rsp  data=%0d carry=%0d tag=%0d err=%0d (exp %0d/%0d/%0d/%0d)",
                   rsp_data, rsp_carry, rsp_tag, rsp_err, e.data, e.carry, e.tag, e.err);
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
          chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
        @(posedge clock); #1;
        if (!reset) begin
          exp_ops = exp_ops + 8'd1;
          chk("op_count", 32'(op_count), 32'(exp_ops));
        end
      end else if (rsp_valid) begin
        stalled = 1'b1;
        held = {rsp_data, rsp_carry, rsp_tag, rsp_err};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t1;
    int n;
    logic [3:0] s;
    logic [7:0] b;

    // Reset state.
    @(posedge clock); @(posedge clock); #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    chk("rst_rsp", 32'({rsp_data, rsp_carry, rsp_tag, rsp_err}), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD 50+25 with ready high.
    rsp_ready = 1'b1;
    send(4'd0, 8'd50, 8'd25, 4'd3, 1'b1);
    wait_drain();
    chk("op_count_first", 32'(op_count), 32'd1);

    // ADD FF+FF stalled for 5 cycles with cmd_valid pushing.
    rsp_ready = 1'b0;
    send(4'd0, 8'hFF, 8'hFF, 4'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_sel = 4'd1;
      cmd_a = 8'($urandom);
      @(posedge clock); #1;
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_alu_a", 32'(alu_a), 32'hFF);
      chk("stall_rsp_carry", 32'(rsp_carry), 32'd1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();

    // Back-to-back SUB then MUL: accept spacing.
    send(4'd1, 8'd20, 8'd7, 4'd1, 1'b0);
    t1 = last_accept;
    send(4'd2, 8'd10, 8'd5, 4'd2, 1'b0);
    chk("accept_gap", last_accept - t1, 32'(LAT + 3));
    wait_drain();

    // Divide by zero and undefined opcode.
    send(4'd3, 8'd100, 8'd0, 4'd6, 1'b1);
    wait_drain();
    send(4'hF, 8'd9, 8'd4, 4'd7, 1'b1);
    wait_drain();

    // Random traffic with random backpressure; crosses the op_count wrap.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      send(s, 8'($urandom), b, 4'($urandom), 1'b0);
      n = int'($urandom_range(0, 2));
      repeat (n) begin
        @(posedge clock); #1;
      end
    end
    rand_ready = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();
    chk("op_count_wrap", 32'(op_count), issued % 256);

    // Reset during WAIT abandons the command.
    send(4'd0, 8'd10, 8'd20, 4'd9, 1'b0);
    reset = 1'b1;
    sb.delete();
    exp_ops = 8'd0;
    issued = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_op_count", 32'(op_count), 32'd0);
      chk("midrst_alu_a", 32'(alu_a), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    send(4'd2, 8'd12, 8'd12, 4'd4, 1'b1);
    wait_drain();
    chk("postrst_op_count", 32'(op_count), 32'd1);

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
